fmeter_uart_rx: RTL and testbench
=================================

// Module: fmeter_uart_rx
// PURPOSE
// Receive end of the frequency-meter serial link. Deserialises 8N1 UART at 57600 bd
// from a 100 MHz clock and parses the meter frame: 8 ASCII decimal digits, MSD first,
// then 0x0D 0x0A. Each good frame loads a 32-bit packed-BCD register and pulses a
// valid strobe. Malformed frames are dropped and flagged. Used in the readout/display
// board and as the checker in meter loopback benches.
// PARAMETERS
// BAUDDIV    1735  bit period = BAUDDIV+1 clocks (1736 clk = 57604 bd at 100 MHz)
// IDLE_BITS  12    line-idle-high bit periods that also resynchronise the parser
// PORTS
// CLK100MHz   in   1   system clock, all logic on rising edge
// RESETn      in   1   asynchronous, active-low reset
// RXD         in   1   serial input, idle high, asynchronous to CLK100MHz
// FREQ_BCD    out  32  last good frame; [31:28] = MSD digit ... [3:0] = LSD digit
// FREQ_VALID  out  1   one-clock pulse when FREQ_BCD is updated
// FRAME_ERR   out  1   one-clock pulse on stop-bit error or protocol error
// RX_ACT      out  1   high while the byte receiver is not in IDLE (LED drive)
// BEHAVIOUR
// Reset: all outputs 0; byte FSM IDLE; parser HUNT; idle counter 0; digit buffer 0.
// RXD passes through a 2-flop synchroniser; all decisions use the synchronised copy.
// Byte FSM:
// - IDLE: synchronised RXD = 0 -> START, bit counter loaded with BAUDDIV/2 (867).
// - START: at terminal count resample. 1 -> IDLE (glitch, no byte, no error).
//   0 -> DATA, counter reloaded with BAUDDIV.
// - DATA: sample once per bit period (terminal count). LSB first; 8 samples -> STOP.
// - STOP: sample at terminal count. 1 -> byte strobe. 0 -> stop error. Either way -> IDLE.
//   The next start edge is accepted the cycle after the return to IDLE.
// - The bit counter counts down BAUDDIV..0; terminal count is the clock where it equals 0.
// Parser (advances on the clock after the byte strobe):
// - HUNT: wait for byte 0x0A, or for the line to stay idle high for IDLE_BITS*(BAUDDIV+1)
//   clocks. Either event -> DIG with digit index 0.
// - DIG: a byte in 0x30..0x39 shifts its low nibble into the buffer and increments the
//   index. After index 7 is accepted -> CR. Any other byte -> FRAME_ERR, then HUNT
//   (0x0A -> DIG index 0 directly).
// - CR: 0x0D -> LF; any other byte -> FRAME_ERR, HUNT (0x0A -> DIG index 0).
// - LF: 0x0A -> FREQ_BCD <= buffer, FREQ_VALID pulse, -> DIG index 0.
//   Any other byte -> FRAME_ERR, HUNT.
// - Stop error in any state -> FRAME_ERR pulse, parser -> HUNT, partial buffer discarded.
// Latency: FREQ_VALID/FRAME_ERR assert exactly 2 clocks after the stop-bit sample clock.
// FREQ_BCD changes only together with FREQ_VALID and holds otherwise.
// The idle counter counts only while in HUNT and the synchronised RXD = 1. It clears on
// any low sample and saturates; it does not run in other parser states.
// FRAME_ERR and FREQ_VALID are never high in the same cycle.
// Reset asserted mid-byte or mid-frame: immediate return to reset values and no pulses.
// After release, the first frame is accepted only via an LF or idle resync from HUNT.
// TESTING
// 1 Reset, 13 idle bit times, then send "00012345\r\n" at 1736 clk/bit
//   -> one FREQ_VALID, FREQ_BCD = 32'h00012345, FRAME_ERR never high.
// 2 Two back-to-back frames "99999999\r\n" then "00000001\r\n", no gap
//   -> two FREQ_VALID pulses, final FREQ_BCD = 32'h00000001.
// 3 RXD low pulse of 600 clocks while idle -> no byte, RX_ACT returns low, no pulses.
// 4 Frame with stop bit of the 4th digit forced 0 -> one FRAME_ERR, FREQ_BCD unchanged;
//   the following good frame "12345678\r\n" -> FREQ_BCD = 32'h12345678.
// 5 "0001A345\r\n" -> FRAME_ERR on the 'A'; the LF resyncs; next "00000042\r\n"
//   -> FREQ_BCD = 32'h00000042.
// 6 RESETn pulsed low during digit 5, then release into a mid-frame stream
//   -> outputs 0, partial frame ignored, first complete frame after an LF accepted.

Source files
------------

// File: rtl/fmeter_uart_rx.sv
// fmeter_uart_rx: 8N1 UART receiver and "DDDDDDDD\r\n" frame parser producing packed-BCD readings
module fmeter_uart_rx #(
   parameter int BAUDDIV   = 1735,
   parameter int IDLE_BITS = 12
) (
   input  logic        CLK100MHz,
   input  logic        RESETn,
   input  logic        RXD,
   output logic [31:0] FREQ_BCD,
   output logic        FREQ_VALID,
   output logic        FRAME_ERR,
   output logic        RX_ACT
);
   localparam int CW        = $clog2(BAUDDIV + 2);
   localparam int IDLE_CLKS = IDLE_BITS * (BAUDDIV + 1);
   localparam int IW        = $clog2(IDLE_CLKS + 1);
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
   typedef enum logic [1:0] {P_HUNT, P_DIG, P_CR, P_LF} pstate_t;
   logic          rxd_m, rxd_s;
   bstate_t       bstate, bstate_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bitn, bitn_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          byte_rdy, rdy_nx, stop_err, serr_nx, tc;
   pstate_t       pstate, pstate_nx;
   logic [2:0]    idx, idx_nx;
   logic [31:0]   dbuf, dbuf_nx;
   logic [IW-1:0] idle_cnt;
   logic          valid_nx, err_nx, is_lf, is_cr, is_dig, idle_hit;
   // synchroniser flops reset high so reset release never looks like a start bit
   always_ff @(posedge CLK100MHz or negedge RESETn)
      if (!RESETn) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= RXD;
         rxd_s <= rxd_m;
      end
   assign tc     = cnt == '0;
   assign RX_ACT = bstate != B_IDLE;
   always_ff @(posedge CLK100MHz or negedge RESETn)
      if (!RESETn) begin
         bstate   <= B_IDLE;
         cnt      <= '0;
         bitn     <= '0;
         shreg    <= '0;
         byte_rdy <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         bstate   <= bstate_nx;
         cnt      <= cnt_nx;
         bitn     <= bitn_nx;
         shreg    <= shreg_nx;
         byte_rdy <= rdy_nx;
         stop_err <= serr_nx;
      end
   always_comb begin
      bstate_nx = bstate;
      cnt_nx    = tc ? cnt : cnt - 1'b1;
      bitn_nx   = bitn;
      shreg_nx  = shreg;
      rdy_nx    = 1'b0;
      serr_nx   = 1'b0;
      case (bstate)
         B_IDLE:
            if (!rxd_s) begin
               bstate_nx = B_START;
               cnt_nx    = CW'(BAUDDIV / 2);
            end
         B_START:
            if (tc) begin
               bstate_nx = rxd_s ? B_IDLE : B_DATA;
               cnt_nx    = CW'(BAUDDIV);
               bitn_nx   = '0;
            end
         B_DATA:
            if (tc) begin
               shreg_nx  = {rxd_s, shreg[7:1]};
               bitn_nx   = bitn + 3'd1;
               cnt_nx    = CW'(BAUDDIV);
               bstate_nx = bitn == 3'd7 ? B_STOP : B_DATA;
            end
         B_STOP:
            if (tc) begin
               rdy_nx    = rxd_s;
               serr_nx   = !rxd_s;
               bstate_nx = B_IDLE;
            end
         default: bstate_nx = B_IDLE;
      endcase
   end
   assign is_lf    = shreg == 8'h0A;
   assign is_cr    = shreg == 8'h0D;
   assign is_dig   = shreg[7:4] == 4'h3 && shreg[3:0] <= 4'd9;
   assign idle_hit = idle_cnt == IW'(IDLE_CLKS);
   always_ff @(posedge CLK100MHz or negedge RESETn)
      if (!RESETn) begin
         pstate     <= P_HUNT;
         idx        <= '0;
         dbuf       <= '0;
         idle_cnt   <= '0;
         FREQ_BCD   <= '0;
         FREQ_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         pstate     <= pstate_nx;
         idx        <= idx_nx;
         dbuf       <= dbuf_nx;
         idle_cnt   <= (pstate != P_HUNT || !rxd_s) ? '0 : idle_hit ? idle_cnt : idle_cnt + 1'b1;
         FREQ_BCD   <= valid_nx ? dbuf : FREQ_BCD;
         FREQ_VALID <= valid_nx;
         FRAME_ERR  <= err_nx;
      end
   // a stray LF is itself a valid frame boundary, so errors on LF resync straight to DIG
   always_comb begin
      pstate_nx = pstate;
      idx_nx    = idx;
      dbuf_nx   = dbuf;
      valid_nx  = 1'b0;
      err_nx    = 1'b0;
      if (stop_err) begin
         err_nx    = 1'b1;
         pstate_nx = P_HUNT;
         idx_nx    = '0;
      end else if (byte_rdy) begin
         case (pstate)
            P_HUNT:
               if (is_lf) begin
                  pstate_nx = P_DIG;
                  idx_nx    = '0;
               end
            P_DIG:
               if (is_dig) begin
                  dbuf_nx   = {dbuf[27:0], shreg[3:0]};
                  idx_nx    = idx + 3'd1;
                  pstate_nx = idx == 3'd7 ? P_CR : P_DIG;
               end else begin
                  err_nx    = 1'b1;
                  pstate_nx = is_lf ? P_DIG : P_HUNT;
                  idx_nx    = '0;
               end
            P_CR:
               if (is_cr) pstate_nx = P_LF;
               else begin
                  err_nx    = 1'b1;
                  pstate_nx = is_lf ? P_DIG : P_HUNT;
                  idx_nx    = '0;
               end
            P_LF: begin
               idx_nx    = '0;
               valid_nx  = is_lf;
               err_nx    = !is_lf;
               pstate_nx = is_lf ? P_DIG : P_HUNT;
            end
            default: pstate_nx = P_HUNT;
         endcase
      end else if (pstate == P_HUNT && idle_hit) begin
         pstate_nx = P_DIG;
         idx_nx    = '0;
      end
   end
endmodule

// File: tb/tb_fmeter_uart_rx.sv
// tb_fmeter_uart_rx: directed frame vectors plus glitch and mid-frame reset sequences
module tb_fmeter_uart_rx;
   localparam int BD  = 15;
   localparam int BIT = BD + 1;
   typedef struct {
      string       txt;
      int          bad;
      int          gap;
      int          nv;
      int          ne;
      logic [31:0] bcd;
   } vec_t;
   logic        CLK100MHz = 1'b0;
   logic        RESETn = 1'b0;
   logic        RXD = 1'b1;
   logic [31:0] FREQ_BCD;
   logic        FREQ_VALID, FRAME_ERR, RX_ACT;
   int          checks = 0, failures = 0;
   int          nvalid = 0, nerr = 0, viol = 0;
   logic [31:0] prev_bcd = '0;
   logic        prev_rst = 1'b0;
   vec_t        vecs[4];
   fmeter_uart_rx #(.BAUDDIV(BD), .IDLE_BITS(12)) dut (
      .CLK100MHz(CLK100MHz), .RESETn(RESETn), .RXD(RXD),
      .FREQ_BCD(FREQ_BCD), .FREQ_VALID(FREQ_VALID), .FRAME_ERR(FRAME_ERR), .RX_ACT(RX_ACT)
   );
   always #5 CLK100MHz = ~CLK100MHz;
   always @(negedge CLK100MHz) begin
      if (FREQ_VALID) nvalid++;
      if (FRAME_ERR) nerr++;
      if (FREQ_VALID && FRAME_ERR) viol++;
      if (RESETn && prev_rst && FREQ_BCD != prev_bcd && !FREQ_VALID) viol++;
      prev_bcd = FREQ_BCD;
      prev_rst = RESETn;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic bits(input int n);
      repeat (n * BIT) @(negedge CLK100MHz);
   endtask
   task automatic send_byte(input logic [7:0] b, input logic stop_b);
      RXD = 1'b0;
      bits(1);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         bits(1);
      end
      RXD = stop_b;
      bits(1);
      RXD = 1'b1;
   endtask
   // 'R' and 'L' in the text stand for CR and LF
   task automatic send_str(input string s, input int bad, input int gap);
      logic [7:0] c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         c = c == "R" ? 8'h0D : c == "L" ? 8'h0A : c;
         send_byte(c, i != bad);
         if (i == bad) bits(gap);
      end
   endtask
   initial begin
      int v0, e0;
      vecs[0] = '{"00012345RL", -1, 0, 1, 0, 32'h00012345};
      vecs[1] = '{"99999999RL00000001RL", -1, 0, 2, 0, 32'h00000001};
      vecs[2] = '{"123412345678RL", 3, 30, 1, 1, 32'h12345678};
      vecs[3] = '{"0001A345RL00000042RL", -1, 0, 1, 1, 32'h00000042};
      repeat (4) @(negedge CLK100MHz);
      chk("rst_bcd", FREQ_BCD, 0);
      chk("rst_valid", {31'b0, FREQ_VALID}, 0);
      chk("rst_err", {31'b0, FRAME_ERR}, 0);
      chk("rst_act", {31'b0, RX_ACT}, 0);
      RESETn = 1'b1;
      bits(13);
      for (int k = 0; k < 4; k++) begin
         v0 = nvalid;
         e0 = nerr;
         send_str(vecs[k].txt, vecs[k].bad, vecs[k].gap);
         bits(2);
         chk($sformatf("v%0d_valid_cnt", k), nvalid - v0, vecs[k].nv);
         chk($sformatf("v%0d_err_cnt", k), nerr - e0, vecs[k].ne);
         chk($sformatf("v%0d_bcd", k), FREQ_BCD, vecs[k].bcd);
      end
      v0 = nvalid;
      e0 = nerr;
      RXD = 1'b0;
      repeat (4) @(negedge CLK100MHz);
      chk("glitch_act_hi", {31'b0, RX_ACT}, 1);
      repeat (1) @(negedge CLK100MHz);
      RXD = 1'b1;
      bits(2);
      chk("glitch_act_lo", {31'b0, RX_ACT}, 0);
      chk("glitch_valid_cnt", nvalid - v0, 0);
      chk("glitch_err_cnt", nerr - e0, 0);
      chk("glitch_bcd", FREQ_BCD, 32'h00000042);
      send_str("1234", -1, 0);
      fork
         send_byte("5", 1'b1);
         begin
            bits(3);
            RESETn = 1'b0;
         end
      join
      chk("midrst_bcd", FREQ_BCD, 0);
      chk("midrst_valid", {31'b0, FREQ_VALID}, 0);
      chk("midrst_err", {31'b0, FRAME_ERR}, 0);
      chk("midrst_act", {31'b0, RX_ACT}, 0);
      v0 = nvalid;
      e0 = nerr;
      RESETn = 1'b1;
      send_str("678RL87654321RL", -1, 0);
      bits(2);
      chk("after_rst_valid_cnt", nvalid - v0, 1);
      chk("after_rst_err_cnt", nerr - e0, 0);
      chk("after_rst_bcd", FREQ_BCD, 32'h87654321);
      chk("overlap_or_stray_bcd", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
